asym_fifo_w2n: RTL

//  Single-clock asymmetric FIFO. Accepts WIDTHW-bit words and returns them as WIDTHR-bit

---
 rtl/asym_fifo_w2n_pkg.sv | 17 +
 rtl/asym_ram_defs.vh | 18 +
 rtl/asym_ram_w2n.sv | 55 +++++
 rtl/asym_fifo_w2n.sv | 125 ++++++++++++
 4 files changed

// File: rtl/asym_fifo_w2n_pkg.sv
// Common types and default geometry for the wide-to-narrow asymmetric FIFO.
package asym_fifo_w2n_pkg;

`include "asym_ram_defs.vh"

  localparam int DEF_WIDTHW     = 32;
  localparam int DEF_WIDTHR     = 8;
  localparam int DEF_DEPTHW     = 64;
  localparam int DEF_ADDRWIDTHW = 6;
  localparam int DEF_ADDRWIDTHR = 8;

  typedef struct packed {
    logic wr;
    logic rd;
  } accept_t;

endpackage

// File: rtl/asym_ram_defs.vh
// Shared definitions for the asymmetric RAM blocks: log2 helper, max/min macros,
// and the lane-order rule (lane 0 = LSBs of the wide word = lowest narrow address).
`ifndef ASYM_RAM_DEFS_VH
`define ASYM_RAM_DEFS_VH

`define ASYM_MAX(a, b) (((a) > (b)) ? (a) : (b))
`define ASYM_MIN(a, b) (((a) < (b)) ? (a) : (b))

function automatic int unsigned asym_log2(input int unsigned value);
  int unsigned res;
  res = 32'd0;
  while ((32'd1 << res) < value) begin
    res = res + 32'd1;
  end
  return res;
endfunction

`endif

// File: rtl/asym_ram_w2n.sv
// Asymmetric storage: wide write port split into lanes, narrow registered read port.
module asym_ram_w2n
  import asym_fifo_w2n_pkg::*;
#(
  parameter int WIDTHW     = DEF_WIDTHW,
  parameter int WIDTHR     = DEF_WIDTHR,
  parameter int DEPTHW     = DEF_DEPTHW,
  parameter int ADDRWIDTHW = DEF_ADDRWIDTHW,
  parameter int ADDRWIDTHR = DEF_ADDRWIDTHR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDRWIDTHW-1:0] waddr_i,
  input  logic [WIDTHW-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [ADDRWIDTHR-1:0] raddr_i,
  output logic [WIDTHR-1:0]     rdata_o
);

  localparam int RATIO     = WIDTHW / WIDTHR;
  localparam int LOG2RATIO = asym_log2(RATIO);
  localparam int CAPR      = DEPTHW * RATIO;

  logic [WIDTHR-1:0]     mem_q [CAPR];
  logic [WIDTHR-1:0]     rdata_q;
  logic [ADDRWIDTHR-1:0] lane_addr_s [RATIO];
  logic [WIDTHR-1:0]     lane_data_s [RATIO];

  for (genvar l = 0; l < RATIO; l++) begin : g_lane
    assign lane_addr_s[l] = {waddr_i, LOG2RATIO'(l)};
    assign lane_data_s[l] = wdata_i[l*WIDTHR +: WIDTHR];
  end

  // Wide write: every lane of the word lands in its own narrow slot
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < RATIO; l++) begin
        mem_q[lane_addr_s[l]] <= lane_data_s[l];
      end
    end
  end

  // Narrow read register; holds its value when no read is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {WIDTHR{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/asym_fifo_w2n.sv
// Single-clock wide-write / narrow-read FIFO built on asym_ram_w2n.
// Define ASYM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module asym_fifo_w2n
  import asym_fifo_w2n_pkg::*;
#(
  parameter int WIDTHW     = DEF_WIDTHW,
  parameter int WIDTHR     = DEF_WIDTHR,
  parameter int DEPTHW     = DEF_DEPTHW,
  parameter int ADDRWIDTHW = DEF_ADDRWIDTHW,
  parameter int ADDRWIDTHR = DEF_ADDRWIDTHR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTHW-1:0]     wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTHR-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDRWIDTHR:0]   level
`ifdef ASYM_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int RATIO     = WIDTHW / WIDTHR;
  localparam int LOG2RATIO = asym_log2(RATIO);
  localparam int CAPR      = DEPTHW * RATIO;
  localparam logic [ADDRWIDTHR:0] FULL_THRESH = (ADDRWIDTHR+1)'(CAPR - RATIO);

  logic [ADDRWIDTHW:0] wptr_q, wptr_d;
  logic [ADDRWIDTHR:0] rptr_q, rptr_d;
  logic [ADDRWIDTHR:0] level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                rd_valid_q, rd_valid_d;
  accept_t             acc_s;

  // Accept decisions and next pointer/flag values, all from pre-edge flags
  always_comb begin
    acc_s.wr   = wr_en & ~full_q;
    acc_s.rd   = rd_en & ~empty_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (acc_s.wr) begin
      wptr_d = wptr_q + (ADDRWIDTHW+1)'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (acc_s.rd) begin
      rptr_d = rptr_q + (ADDRWIDTHR+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
    // Word pointer scaled to units; the wrap bit makes the modular difference exact
    level_d    = {wptr_d, {LOG2RATIO{1'b0}}} - rptr_d;
    full_d     = (level_d > FULL_THRESH);
    empty_d    = (level_d == {(ADDRWIDTHR+1){1'b0}});
    rd_valid_d = acc_s.rd;
  end

  // State register for pointers, occupancy and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= {(ADDRWIDTHW+1){1'b0}};
      rptr_q     <= {(ADDRWIDTHR+1){1'b0}};
      level_q    <= {(ADDRWIDTHR+1){1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  asym_ram_w2n #(
    .WIDTHW    (WIDTHW),
    .WIDTHR    (WIDTHR),
    .DEPTHW    (DEPTHW),
    .ADDRWIDTHW(ADDRWIDTHW),
    .ADDRWIDTHR(ADDRWIDTHR)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (acc_s.wr),
    .waddr_i(wptr_q[ADDRWIDTHW-1:0]),
    .wdata_i(wr_data),
    .re_i   (acc_s.rd),
    .raddr_i(rptr_q[ADDRWIDTHR-1:0]),
    .rdata_o(rd_data)
  );

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign rd_valid = rd_valid_q;

`ifdef ASYM_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (wr_en & full_q);
      underflow_q <= underflow_q | (rd_en & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
